// File: rtl/add_num_rd_engine.sv
// CCI-P c0 read engine for the add-two-numbers AFU: reads N lines from a base address,
// adds two operands per returned line and queues the sums in a credit-limited FIFO.
module add_num_rd_engine #(
  parameter int unsigned ADDR_W = 42,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned OPW    = 8,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  line_cnt,
  output logic              c0_req_valid,
  output logic [ADDR_W-1:0] c0_req_addr,
  output logic [CNT_W-1:0]  c0_req_mdata,
  input  logic              c0TxAlmFull,
  input  logic              c0_rsp_valid,
  input  logic [CNT_W-1:0]  c0_rsp_mdata,
  input  logic [511:0]      c0_rsp_data,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic [OPW:0]      sum_data,
  output logic [CNT_W-1:0]  sum_idx,
  output logic              busy,
  output logic              done,
  output logic              stray_err
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = CNT_W + OPW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, FINISH = 2'd3} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  cnt_q, issued_q, received_q;
  logic [CW-1:0]     outstanding_q, count_q, count_d;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [EW-1:0]     mem_q [DEPTH];

  logic              credit_ok_c, issue_c, last_issue_c, accept_c, stray_c, pop_c, start_c;
  logic [OPW:0]      sum_c;
  logic              req_valid_d, busy_d, done_d;
  logic [ADDR_W-1:0] req_addr_d;
  logic [CNT_W-1:0]  req_mdata_d;
  logic              unused_c;

  // Credit check on pre-update values: every in-flight read owns a FIFO slot.
  assign credit_ok_c  = ((CW+1)'(outstanding_q) + (CW+1)'(count_q)) < (CW+1)'(DEPTH);
  assign issue_c      = (state_q == ISSUE) && !c0TxAlmFull && credit_ok_c && (issued_q != cnt_q);
  assign last_issue_c = issue_c && ((issued_q + CNT_W'(1)) == cnt_q);
  assign start_c      = (state_q == IDLE) && start;
  assign accept_c     = c0_rsp_valid && (outstanding_q != '0);
  assign stray_c      = c0_rsp_valid && (outstanding_q == '0);
  assign pop_c        = sum_valid && sum_ready;
  assign sum_c        = (OPW+1)'(c0_rsp_data[OPW-1:0]) + (OPW+1)'(c0_rsp_data[2*OPW-1:OPW]);
  assign count_d      = count_q + CW'(accept_c) - CW'(pop_c);
  assign unused_c     = ^c0_rsp_data[511:2*OPW];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (line_cnt == '0) ? FINISH : ISSUE;
      ISSUE:   if (last_issue_c) state_d = WAIT;
      WAIT:    if ((received_q == cnt_q) && (count_q == '0)) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_valid_d = issue_c;
    req_addr_d  = c0_req_addr;
    req_mdata_d = c0_req_mdata;
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == FINISH);
    if (issue_c) begin
      req_addr_d  = base_q + ADDR_W'(issued_q);
      req_mdata_d = issued_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c0_req_valid <= 1'b0;
      c0_req_addr  <= '0;
      c0_req_mdata <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sum_valid    <= 1'b0;
    end else begin
      c0_req_valid <= req_valid_d;
      c0_req_addr  <= req_addr_d;
      c0_req_mdata <= req_mdata_d;
      busy         <= busy_d;
      done         <= done_d;
      sum_valid    <= (count_d != '0);
    end
  end

  // Job counters, outstanding-read tracking, FIFO pointers and the sticky stray flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q        <= '0;
      cnt_q         <= '0;
      issued_q      <= '0;
      received_q    <= '0;
      outstanding_q <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      stray_err     <= 1'b0;
    end else begin
      if (start_c) begin
        base_q        <= base_addr;
        cnt_q         <= line_cnt;
        issued_q      <= '0;
        received_q    <= '0;
        outstanding_q <= '0;
      end else begin
        if (issue_c)  issued_q   <= issued_q + CNT_W'(1);
        if (accept_c) received_q <= received_q + CNT_W'(1);
        case ({issue_c, accept_c})
          2'b10:   outstanding_q <= outstanding_q + CW'(1);
          2'b01:   outstanding_q <= outstanding_q - CW'(1);
          default: outstanding_q <= outstanding_q;
        endcase
      end
      if (stray_c)      stray_err <= 1'b1;
      else if (start_c) stray_err <= 1'b0;
      count_q <= count_d;
      if (accept_c) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_c)    rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (accept_c) begin
      mem_q[wr_ptr_q] <= {c0_rsp_mdata, sum_c};
    end
  end

  assign {sum_idx, sum_data} = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_add_num_rd_engine.sv
// Randomized scoreboard bench for add_num_rd_engine: a responder models host memory,
// a negedge monitor checks requests, credits, sums and done pulses.
module tb_add_num_rd_engine;
  localparam int unsigned ADDR_W = 42;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned OPW    = 8;
  localparam int unsigned DEPTH  = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  line_cnt;
  logic              c0_req_valid;
  logic [ADDR_W-1:0] c0_req_addr;
  logic [CNT_W-1:0]  c0_req_mdata;
  logic              c0TxAlmFull;
  logic              c0_rsp_valid;
  logic [CNT_W-1:0]  c0_rsp_mdata;
  logic [511:0]      c0_rsp_data;
  logic              sum_valid;
  logic              sum_ready;
  logic [OPW:0]      sum_data;
  logic [CNT_W-1:0]  sum_idx;
  logic              busy;
  logic              done;
  logic              stray_err;

  add_num_rd_engine #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .OPW(OPW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .line_cnt(line_cnt),
    .c0_req_valid(c0_req_valid), .c0_req_addr(c0_req_addr), .c0_req_mdata(c0_req_mdata),
    .c0TxAlmFull(c0TxAlmFull), .c0_rsp_valid(c0_rsp_valid), .c0_rsp_mdata(c0_rsp_mdata),
    .c0_rsp_data(c0_rsp_data), .sum_valid(sum_valid), .sum_ready(sum_ready),
    .sum_data(sum_data), .sum_idx(sum_idx), .busy(busy), .done(done), .stray_err(stray_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0]     exp_base = '0;
  int                    req_seen = 0, popped = 0, popped_lag = 0, done_cnt = 0, job_d0 = 0;
  int                    pend[$];
  int                    order_list[$];
  int                    pop_idx[$];
  logic [CNT_W+OPW:0]    sb[$];
  logic [CNT_W+OPW:0]    last_pop = '0;
  int                    rsp_mode = 0, rsp_gap = 0, ready_mode = 1, alm_mode = 0;
  bit                    fixed_en = 0, force_stray = 0;
  logic [15:0]           fixed_val = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: request order/address/credit rules, scoreboard pops, output stability, done pulses.
  logic               prev_alm = 1'b0, prev_done = 1'b0, hold_v = 1'b0;
  logic [CNT_W+OPW:0] hold_e = '0;
  always @(negedge clk) begin
    logic [ADDR_W-1:0]  ea;
    logic [CNT_W+OPW:0] e;
    int                 pop_entry;
    if (!reset_n) begin
      hold_v = 1'b0; prev_done = 1'b0; prev_alm = 1'b0;
    end else begin
      pop_entry = popped;
      if (c0_req_valid) begin
        ea = exp_base + ADDR_W'(req_seen);
        check("req_addr", c0_req_addr, ea);
        check("req_tag", c0_req_mdata, CNT_W'(req_seen));
        check("req_almfull", prev_alm, 1'b0);
        check("req_credit", ((req_seen + 1 - popped_lag) <= DEPTH), 1'b1);
        pend.push_back(int'(c0_req_mdata));
        req_seen++;
      end
      if (hold_v) begin
        check("hold_valid", sum_valid, 1'b1);
        check("hold_data", {sum_idx, sum_data}, hold_e);
      end
      if (sum_valid && sum_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL sum_unexpected: got 0x%0h expected no sum", {sum_idx, sum_data});
        end else begin
          e = sb.pop_front();
          check("sum", {sum_idx, sum_data}, e);
        end
        last_pop = {sum_idx, sum_data};
        pop_idx.push_back(int'(sum_idx));
        popped++;
      end
      if (done && prev_done) begin
        checks++; errors++;
        $display("FAIL done_width: got 2+ cycles expected 1");
      end
      if (done) done_cnt++;
      hold_v = sum_valid && !sum_ready;
      hold_e = {sum_idx, sum_data};
      prev_alm = c0TxAlmFull;
      prev_done = done;
      popped_lag = pop_entry;
    end
  end

  // Host-memory responder: returns outstanding tags according to rsp_mode.
  always @(posedge clk) begin
    int           k;
    int           tag;
    logic [511:0] d;
    logic [OPW:0] s;
    #1;
    c0_rsp_valid = 1'b0;
    for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom();
    if (force_stray) begin
      force_stray = 0;
      c0_rsp_valid = 1'b1; c0_rsp_mdata = CNT_W'(16'h55); c0_rsp_data = d;
    end else if (reset_n && rsp_mode != 0 && pend.size() > 0 && $urandom_range(0, rsp_gap) == 0) begin
      k = -1;
      case (rsp_mode)
        1: k = 0;
        2: k = $urandom_range(0, pend.size() - 1);
        default: if (order_list.size() > 0)
                   foreach (pend[i]) if (pend[i] == order_list[0]) k = i;
      endcase
      if (k >= 0) begin
        tag = pend[k];
        pend.delete(k);
        if (rsp_mode == 3) void'(order_list.pop_front());
        if (fixed_en) d[15:0] = fixed_val;
        s = {1'b0, d[7:0]} + {1'b0, d[15:8]};
        c0_rsp_valid = 1'b1; c0_rsp_mdata = CNT_W'(tag); c0_rsp_data = d;
        sb.push_back({CNT_W'(tag), s});
      end
    end
  end

  always @(posedge clk) begin
    #1;
    sum_ready   = (ready_mode == 0) ? 1'b0 : (ready_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    c0TxAlmFull = (alm_mode != 0) && ($urandom_range(0, 2) == 0);
  end

  task automatic start_job(input logic [ADDR_W-1:0] base, input int cnt);
    @(posedge clk); #2;
    exp_base = base; req_seen = 0; popped = 0; popped_lag = 0; job_d0 = done_cnt;
    pop_idx.delete();
    base_addr = base; line_cnt = CNT_W'(cnt); start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done_cnt == job_d0 && n < budget) begin @(posedge clk); n++; end
    checks++;
    if (done_cnt == job_d0) begin
      errors++;
      $display("FAIL %s_done_timeout: got no done expected done within %0d cycles", name, budget);
    end
  endtask

  task automatic finish_checks(input string name, input int cnt);
    repeat (3) @(posedge clk);
    #2;
    check({name, "_reqs"}, req_seen, cnt);
    check({name, "_sums"}, popped, cnt);
    check({name, "_sb_left"}, sb.size(), 0);
    check({name, "_pend_left"}, pend.size(), 0);
    check({name, "_done_pulses"}, done_cnt - job_d0, 1);
    check({name, "_busy"}, busy, 1'b0);
    check({name, "_stray"}, stray_err, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n = 1'b1; start = 1'b0; base_addr = '0; line_cnt = '0;
    c0_rsp_valid = 1'b0; c0_rsp_mdata = '0; c0_rsp_data = '0; sum_ready = 1'b1; c0TxAlmFull = 1'b0;
    #1 reset_n = 1'b0;
    #2;
    check("rst_req_valid", c0_req_valid, 1'b0);
    check("rst_req_addr", c0_req_addr, '0);
    check("rst_req_mdata", c0_req_mdata, '0);
    check("rst_sum_valid", sum_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_stray", stray_err, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Single line, directed operands 3 + 5.
    rsp_mode = 1; rsp_gap = 0; ready_mode = 1; fixed_en = 1; fixed_val = 16'h0503;
    start_job(ADDR_W'(42'h100), 1);
    wait_done("single", 100);
    finish_checks("single", 1);
    check("single_sum", last_pop, {CNT_W'(0), 9'h008});

    // Carry out of the operand width.
    fixed_val = 16'hFFFF;
    start_job(ADDR_W'(42'h2000), 1);
    wait_done("carry", 100);
    finish_checks("carry", 1);
    check("carry_sum", last_pop, {CNT_W'(0), 9'h1FE});
    fixed_en = 0;

    // Credits: with the consumer stalled only DEPTH reads may be in flight.
    ready_mode = 0;
    start_job(ADDR_W'({$urandom(), $urandom()}), 20);
    repeat (40) @(posedge clk);
    #2;
    check("credit_reqs", req_seen, DEPTH);
    check("credit_valid", sum_valid, 1'b1);
    check("credit_req_idle", c0_req_valid, 1'b0);
    ready_mode = 2;
    wait_done("credit", 2000);
    finish_checks("credit", 20);

    // Out-of-order returns with almost-full toggling.
    ready_mode = 1; alm_mode = 1; rsp_mode = 3; order_list = '{2, 0, 3, 1};
    start_job(ADDR_W'({$urandom(), $urandom()}), 4);
    wait_done("ooo", 500);
    finish_checks("ooo", 4);
    check("ooo_n", pop_idx.size(), 4);
    if (pop_idx.size() == 4) begin
      check("ooo_idx0", pop_idx[0], 2);
      check("ooo_idx1", pop_idx[1], 0);
      check("ooo_idx2", pop_idx[2], 3);
      check("ooo_idx3", pop_idx[3], 1);
    end

    // Address wrap at the top of the cache-line space.
    rsp_mode = 2; alm_mode = 0; rsp_gap = 1;
    start_job({ADDR_W{1'b1}} - ADDR_W'(2), 5);
    wait_done("wrap", 500);
    finish_checks("wrap", 5);

    // Randomized jobs.
    for (int j = 0; j < 5; j++) begin
      int cnt;
      cnt = $urandom_range(1, 25);
      rsp_mode = $urandom_range(1, 2); rsp_gap = $urandom_range(0, 3);
      ready_mode = 2; alm_mode = $urandom_range(0, 1);
      start_job(ADDR_W'({$urandom(), $urandom()}), cnt);
      wait_done("rand", 3000);
      finish_checks("rand", cnt);
    end

    // Zero-length job.
    rsp_mode = 1; rsp_gap = 0; ready_mode = 1; alm_mode = 0;
    start_job(ADDR_W'(42'h300), 0);
    wait_done("zero", 2);
    finish_checks("zero", 0);

    // Start while busy is ignored.
    ready_mode = 2; rsp_gap = 2;
    start_job(ADDR_W'(42'h4000), 5);
    @(posedge clk); #2;
    base_addr = ADDR_W'(42'h9999); line_cnt = CNT_W'(3); start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    wait_done("busy_start", 1000);
    finish_checks("busy_start", 5);

    // Stray response while idle.
    ready_mode = 1; rsp_gap = 0;
    @(posedge clk); #2;
    force_stray = 1;
    repeat (3) @(posedge clk);
    #2;
    check("stray_set", stray_err, 1'b1);
    check("stray_no_sum", sum_valid, 1'b0);
    start_job(ADDR_W'(42'h500), 1);
    check("stray_cleared", stray_err, 1'b0);
    wait_done("stray_job", 100);
    finish_checks("stray_job", 1);

    // Reset in the middle of a job.
    rsp_mode = 0;
    start_job(ADDR_W'(42'h600), 6);
    n = 0;
    while (req_seen < 3 && n < 50) begin @(posedge clk); n++; end
    check("mid_reached", (req_seen >= 3), 1'b1);
    #1 reset_n = 1'b0;
    #1;
    check("mid_req_valid", c0_req_valid, 1'b0);
    check("mid_req_addr", c0_req_addr, '0);
    check("mid_req_mdata", c0_req_mdata, '0);
    check("mid_sum_valid", sum_valid, 1'b0);
    check("mid_sum", {sum_idx, sum_data}, '0);
    check("mid_busy", busy, 1'b0);
    check("mid_done", done, 1'b0);
    check("mid_stray", stray_err, 1'b0);
    pend.delete(); sb.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    rsp_mode = 1;
    start_job(ADDR_W'(42'h700), 2);
    wait_done("post_rst", 200);
    finish_checks("post_rst", 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/add_num_rd_engine.md
Name: add_num_rd_engine

Overview:
- Host-memory read side of the add-two-numbers AFU. It complements the existing c1 write path.
- On a start pulse it issues N single-line CCI-P c0 read requests from a base cache-line address.
- For each returned line it extracts two operands and adds them.
- Sums stream out through a valid/ready FIFO interface to the result-write logic, with a credit scheme so responses are never back-pressured.

Parameters:
ADDR_W, 42, cache-line address width (t_ccip_clAddr)
CNT_W, 16, width of line count and line index
OPW, 8, operand width; operand a = data[OPW-1:0], b = data[2*OPW-1:OPW]
DEPTH, 8, result FIFO depth (power of 2); also the credit limit

Ports:
clk  in  1  AFU clock (host_ccip.clk)
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; sampled only in IDLE
base_addr  in  ADDR_W  first cache-line address; latched on accepted start
line_cnt  in  CNT_W  number of lines to read; latched on accepted start
c0_req_valid  out  1  read request strobe
c0_req_addr  out  ADDR_W  request address
c0_req_mdata  out  CNT_W  request tag = line index
c0TxAlmFull  in  1  c0 request channel almost full
c0_rsp_valid  in  1  read response valid (c0 resp_type = read)
c0_rsp_mdata  in  CNT_W  returned tag
c0_rsp_data  in  512  returned line
sum_valid  out  1  FIFO head valid
sum_ready  in  1  consumer accept
sum_data  out  OPW+1  a+b, zero-extended operands, carry in MSB
sum_idx  out  CNT_W  line index of this sum
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse
stray_err  out  1  sticky: response received with no read outstanding

Behaviour:
- Reset (async assert, sync deassert use) clears all of the following to 0: state=IDLE, c0_req_valid, c0_req_mdata, c0_req_addr, issue/recv counters, outstanding, FIFO pointers, sum_valid, busy, done, stray_err.
- Reset mid-operation aborts the job; the FIFO is emptied.
- States: IDLE, ISSUE, WAIT, FINISH.
- IDLE, start=1:
  - latch base_addr and line_cnt; clear counters and stray_err.
  - line_cnt=0 -> FINISH; else -> ISSUE.
  - start in any other state is ignored.
- ISSUE:
  - Issue condition: !c0TxAlmFull && (outstanding + fifo_count) < DEPTH.
  - When met: registered c0_req_valid=1 for one cycle, c0_req_addr=base+issued (mod 2^ADDR_W), c0_req_mdata=issued, then issued++.
  - Otherwise c0_req_valid=0.
  - Back-to-back issue every cycle is allowed.
  - Last request issued -> WAIT.
- Response, in any non-IDLE state:
  - If outstanding>0: push {mdata, a+b} to the FIFO, outstanding--, received++. Latency from c0_rsp_valid to sum_valid is 1 cycle when the FIFO was empty.
  - If outstanding=0: drop the response and set stray_err. This also applies in IDLE.
  - Responses may arrive out of order. Sums are emitted in arrival order; consumers use sum_idx.
- Simultaneous issue and response in one cycle: outstanding is unchanged. The credit check uses pre-update values, so the FIFO can never overflow.
- Simultaneous FIFO push and pop: both occur, count unchanged. A pop on full plus a push is legal.
- FIFO output: sum_valid = !empty; pop when sum_valid && sum_ready. sum_data and sum_idx stay stable while sum_valid && !sum_ready.
- WAIT -> FINISH when received==line_cnt and the FIFO is empty.
- FINISH: done=1 for exactly one cycle, -> IDLE. busy falls the same cycle as state returns to IDLE.
- Addition: zero-extended, OPW+1 bits, no truncation. Bits above 2*OPW of the line are ignored.

Test Plan:
- Single line: base=0x100, cnt=1, response data[15:0]=0x0503 -> one request addr 0x100 tag 0; sum_data=0x008, sum_idx=0; done 1 cycle after the pop.
- Carry: a=0xFF, b=0xFF -> sum_data=0x1FE.
- Throughput and credits: cnt=20, sum_ready=0, responses immediate -> exactly 8 requests issued, then c0_req_valid stays 0. Raising sum_ready drains the FIFO. All 20 sums are delivered, addresses base..base+19, then one done.
- Out-of-order and almfull: cnt=4, responses returned with tags 2,0,3,1, c0TxAlmFull toggled -> no request while almfull; sum_idx sequence 2,0,3,1 with correct sums.
- Edge cases: cnt=0 -> no requests, done 2 cycles after start. start asserted while busy -> ignored. Response in IDLE -> stray_err=1, no sum emitted; the next start clears it.
- Reset mid-job: assert reset_n=0 after 3 of 6 requests -> all outputs 0 immediately. After release a new start cnt=2 completes normally.
